// File: rtl/neuron_mac_if.sv
// Stream bundle for neuron_mac_acc: (weight, activation, bias) beats in,
// saturated pre-activation result out.
interface neuron_mac_if #(
    parameter int W_A   = 8,
    parameter int W_W   = 8,
    parameter int W_OUT = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [W_A-1:0]   in_act;
    logic [W_W-1:0]   in_weight;
    logic             in_last;
    logic [W_OUT-1:0] bias;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_data;
    logic             out_sat;
    logic             busy;

    modport master (
        output in_valid, in_act, in_weight, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_act, in_weight, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/neuron_mac_acc.sv
// Serial MAC for one neuron: product stage, accumulator, round/shift/saturate.
// Optional NEURON_MAC_ROUND_EN selects round-half-up instead of truncation.
module neuron_mac_acc #(
    parameter int W_A   = 8,
    parameter int F_A   = 7,
    parameter int W_W   = 8,
    parameter int F_W   = 6,
    parameter int W_ACC = 24,
    parameter int W_OUT = 10,
    parameter int OUT_I = 4
) (
    input logic        clock,
    input logic        reset,
    neuron_mac_if.slave bus
);
    localparam int OUT_F = W_OUT - OUT_I;
    localparam int SHIFT = F_A + F_W - OUT_F;
    localparam int W_P   = W_A + W_W;

    localparam logic        [W_ACC-1:0] HALF    = W_ACC'(1) << (SHIFT - 1);
    localparam logic signed [W_ACC-1:0] SAT_MAX = W_ACC'((1 << (W_OUT - 1)) - 1);
    localparam logic signed [W_ACC-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_CONV,
        S_OUTPUT
    } state_e;

    state_e state_q, state_d;
    logic   drain_q, drain_d;

    logic                    p_valid_q, p_first_q;
    logic signed [W_P-1:0]   prod_q;
    logic signed [W_OUT-1:0] bias_q;
    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic signed [W_ACC-1:0] rnd_q, rnd_d;
    logic        [W_OUT-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic ready_c, accept_c;

    assign ready_c  = (state_q == S_IDLE || state_q == S_ACCUM) && !reset;
    assign accept_c = bus.in_valid && ready_c;

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            S_IDLE:   if (accept_c) state_d = bus.in_last ? S_FLUSH : S_ACCUM;
            S_ACCUM:  if (accept_c && bus.in_last) state_d = S_FLUSH;
            // Hold until the last product has passed through acc and rnd.
            S_FLUSH:  if (drain_q) state_d = S_CONV; else drain_d = 1'b1;
            S_CONV:   state_d = S_OUTPUT;
            S_OUTPUT: if (bus.out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = ready_c;
        bus.busy      = (state_q != S_IDLE);
        bus.out_valid = (state_q == S_OUTPUT);
        bus.out_data  = out_data_q;
        bus.out_sat   = out_sat_q;
    end

    // ---------------- Stage 1: product ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            prod_q    <= '0;
            bias_q    <= '0;
        end else begin
            p_valid_q <= accept_c;
            if (accept_c) begin
                prod_q    <= $signed(bus.in_act) * $signed(bus.in_weight);
                p_first_q <= (state_q == S_IDLE);
                if (state_q == S_IDLE) bias_q <= $signed(bus.bias);
            end
        end
    end

    // ---------------- Stage 2: accumulate (wraps modulo 2^W_ACC) ----------------
    always_comb begin
        acc_d = acc_q;
        if (p_valid_q) begin
            if (p_first_q)
                acc_d = ({{(W_ACC-W_OUT){bias_q[W_OUT-1]}}, bias_q} <<< SHIFT)
                        + {{(W_ACC-W_P){prod_q[W_P-1]}}, prod_q};
            else
                acc_d = acc_q + {{(W_ACC-W_P){prod_q[W_P-1]}}, prod_q};
        end
    end

    // ---------------- Stage 3: round and shift, then saturate ----------------
    always_comb begin
`ifdef NEURON_MAC_ROUND_EN
        rnd_d = $signed(acc_q + HALF) >>> SHIFT;
`else
        rnd_d = acc_q >>> SHIFT;
`endif
        out_data_d = rnd_q[W_OUT-1:0];
        out_sat_d  = 1'b0;
        if (rnd_q > SAT_MAX) begin
            out_data_d = SAT_MAX[W_OUT-1:0];
            out_sat_d  = 1'b1;
        end else if (rnd_q < SAT_MIN) begin
            out_data_d = SAT_MIN[W_OUT-1:0];
            out_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            rnd_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rnd_q <= rnd_d;
            if (state_q == S_CONV) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: hand-computed results, latency,
// backpressure and mid-operation reset.
module tb_neuron_mac_acc;
    localparam int W_A   = 8;
    localparam int W_W   = 8;
    localparam int W_OUT = 10;

    logic clock;
    logic reset;
    int   n_compared;
    int   n_mismatch;

    neuron_mac_if #(.W_A(W_A), .W_W(W_W), .W_OUT(W_OUT)) bus ();

    neuron_mac_acc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive n back-to-back beats (optional one-cycle bubble between them).
    task automatic send(input int n, input int act, input int wt, input int bias_v,
                        input bit last_on_end, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_act    = W_A'(act);
            bus.in_weight = W_W'(wt);
            bus.bias      = W_OUT'(bias_v);
            bus.in_last   = last_on_end && (i == n - 1);
            tick();
            if (gap && i < n - 1) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vector(input string tag, input int n, input int act, input int wt,
                              input int bias_v, input bit gap, input int exp_data,
                              input int exp_sat);
        int cyc;
        send(n, act, wt, bias_v, 1'b1, gap);
        check({tag, "_busy"}, int'(bus.busy), 1);
        check({tag, "_ready_low"}, int'(bus.in_ready), 0);
        wait_valid(cyc);
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_data"}, int'($signed(bus.out_data)), exp_data);
        check({tag, "_sat"}, int'(bus.out_sat), exp_sat);
        tick();
        check({tag, "_valid_clr"}, int'(bus.out_valid), 0);
        check({tag, "_ready_back"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int cyc;
        int exp_rnd;
        n_compared    = 0;
        n_mismatch    = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_weight = '0;
        bus.in_last   = 1'b0;
        bus.bias      = '0;
        bus.out_ready = 1'b1;

        tick();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_sat", int'(bus.out_sat), 0);
        check("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", int'(bus.in_ready), 1);

        // 64*64 = 4096 >>> 7 = 32 (0.5)
        run_vector("single", 1, 64, 64, 0, 1'b0, 32, 0);
        // 8192 + 3*4096 = 20480 >>> 7 = 160 (2.5); bubbles in ACCUM
        run_vector("three", 3, 64, 64, 64, 1'b1, 160, 0);
        // 8*16129 = 129032 >>> 7 = 1008 -> 511
        run_vector("sat_pos", 8, 127, 127, 0, 1'b0, 511, 1);
        // 8*-16256 = -130048 >>> 7 = -1016 -> -512
        run_vector("sat_neg", 8, -128, 127, 0, 1'b0, -512, 1);
        // 64 >>> 7 = 0 truncated, (64+64) >>> 7 = 1 rounded
`ifdef NEURON_MAC_ROUND_EN
        exp_rnd = 1;
`else
        exp_rnd = 0;
`endif
        run_vector("round", 1, 1, 64, 0, 1'b0, exp_rnd, 0);
        // -1*1 = -1 -> floor -1 truncated, (-1+64)>>>7 = 0 rounded
        run_vector("round_neg", 1, -1, 1, 0, 1'b0, exp_rnd - 1, 0);

        // Backpressure: result held, new beats ignored
        bus.out_ready = 1'b0;
        send(1, 64, 64, 0, 1'b1, 1'b0);
        wait_valid(cyc);
        check("bp_latency", cyc, 3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_act    = W_A'(5);
            bus.in_weight = W_W'(7);
            bus.in_last   = 1'b1;
            tick();
            check("bp_data", int'($signed(bus.out_data)), 32);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_valid", int'(bus.out_valid), 1);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_valid_clr", int'(bus.out_valid), 0);
        check("bp_in_ready", int'(bus.in_ready), 1);
        check("bp_busy", int'(bus.busy), 0);

        // Reset after 2 of 4 beats, then a fresh vector
        send(2, 100, 100, 64, 1'b0, 1'b0);
        check("mid_busy", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_valid", int'(bus.out_valid), 0);
        tick();
        check("mid_rst_idle", int'(bus.busy), 0);
        run_vector("after_rst", 1, 64, 64, 0, 1'b0, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
